wb_regfile: RTL



---
 rtl/wb_regfile_pkg.sv | 18 +
 rtl/wb_mux.sv | 35 +++
 rtl/wb_regfile.sv | 111 +++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared CPU package: writeback source encodings used by the decoder, the
// mem_wb pipeline stage, the forwarding unit and the register file.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

    // Writeback source select. Encoding 3 is unused by the decoder and falls
    // back to the ALU result so that a stray code can never select garbage.
    typedef enum logic [1:0] {
        SEL_ALU     = 2'd0,
        SEL_MEM     = 2'd1,
        SEL_PC4     = 2'd2,
        SEL_ALU_ALT = 2'd3
    } sel_data_e;

endpackage

// File: rtl/wb_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
// 4:1 writeback source select, shared by the register file and the
// forwarding unit so both always agree on the value being written back.
// Ports:
//   sel      in  2       writeback source select (sel_data_e encoding)
//   alu_res  in  DATA_W  ALU result
//   mem_data in  DATA_W  load data
//   pc4      in  DATA_W  link value (PC+4)
//   data     out DATA_W  selected writeback value (combinational)
// -----------------------------------------------------------------------------
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] pc4,
    output logic [DATA_W-1:0] data
);

    // NOTE: the output is given a default before the case so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        data = alu_res;
        case (sel_data_e'(sel))
            SEL_MEM: data = mem_data;
            SEL_PC4: data = pc4;
            default: data = alu_res;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus 2-read/1-write register file with write-through
// bypass, a retired-instruction counter and the PC of the last retirement.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   WB_valid                 WB slot holds a real instruction
//   WB_wr_en                 instruction writes a register
//   WB_sel_data              writeback source select
//   WB_wraddr                destination register
//   WB_ALUres/dataout/pc4    writeback candidates
//   pc_WB                    PC of the WB-stage instruction
//   rd_addr1/2, rd_data1/2   ID-stage combinational read ports
//   wb_data                  selected writeback value (forwarding)
//   wb_commit                a register write happens this cycle
//   retired_count            retired-instruction counter (wraps)
//   last_pc                  PC of the most recently retired instruction
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_valid,
    input  logic              WB_wr_en,
    input  logic [1:0]        WB_sel_data,
    input  logic [ADDR_W-1:0] WB_wraddr,
    input  logic [DATA_W-1:0] WB_ALUres,
    input  logic [DATA_W-1:0] WB_dataout,
    input  logic [DATA_W-1:0] WB_pc4,
    input  logic [DATA_W-1:0] pc_WB,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [31:0]       retired_count,
    output logic [DATA_W-1:0] last_pc
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [31:0]       retired_count_q, retired_count_d;
    logic [DATA_W-1:0] last_pc_q, last_pc_d;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel      (WB_sel_data),
        .alu_res  (WB_ALUres),
        .mem_data (WB_dataout),
        .pc4      (WB_pc4),
        .data     (wb_data)
    );

    // Gating with !rst makes reset win over a coincident writeback and also
    // suppresses the read bypass while reset is asserted.
    assign wb_commit = WB_valid & WB_wr_en & (WB_wraddr != '0) & ~rst;

    // Register 0 is hard-wired to zero; the bypass gives same-cycle visibility
    // of the value being written. Both ports share this function, so equal
    // addresses always return identical data.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        else if (wb_commit && (addr == WB_wraddr))
            return wb_data;
        else
            return regs_q[addr];
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

    always_comb begin
        regs_d          = regs_q;
        retired_count_d = retired_count_q;
        last_pc_d       = last_pc_q;
        if (wb_commit)
            regs_d[WB_wraddr] = wb_data;
        if (WB_valid) begin
            retired_count_d = retired_count_q + 32'd1;  // wraps silently
            last_pc_d       = pc_WB;
        end
    end

    // NOTE: the register array is reset together with the counters because
    // software relies on every register reading 0 after reset; state is
    // updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q          <= '{default: '0};
            retired_count_q <= '0;
            last_pc_q       <= '0;
        end else begin
            regs_q          <= regs_d;
            retired_count_q <= retired_count_d;
            last_pc_q       <= last_pc_d;
        end
    end

    assign retired_count = retired_count_q;
    assign last_pc       = last_pc_q;

endmodule
